// File: rtl/cp0_intc.sv
// cp0_intc - coprocessor-0 interrupt controller for the single-cycle MIPS core.
//
// Edge-detects NUM_SRC request lines into sticky pending bits, picks the
// lowest-index unmasked pending source and redirects the core to that
// source's handler vector. Nested exceptions are held on an EPC/id stack
// of STACK_DEPTH entries; ERET pops the stack.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   exp_src               raw request levels, synchronous to clk
//   pc_in                 PC of the instruction in the current cycle
//   cp0_we/sel/wdata      MTC0 write (sel 0 EPC, 1 STATUS, 2 MASK, 3 CAUSE, 4 PENDING)
//   eret                  ERET executing this cycle
//   cp0_rdata             MFC0 read data for cp0_sel (combinational)
//   exp_take, exp_vector  exception taken this cycle and its handler address
//   epc                   top-of-stack return address (0 when empty)
//   nest_level            current stack depth
//   stack_full            nest_level == STACK_DEPTH
module cp0_intc #(
  parameter int          NUM_SRC     = 3,
  parameter int          STACK_DEPTH = 4,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010,
  localparam int         LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] exp_src,
  input  logic [31:0]        pc_in,
  input  logic               cp0_we,
  input  logic [2:0]         cp0_sel,
  input  logic [31:0]        cp0_wdata,
  input  logic               eret,
  output logic [31:0]        cp0_rdata,
  output logic               exp_take,
  output logic [31:0]        exp_vector,
  output logic [31:0]        epc,
  output logic [LVL_W-1:0]   nest_level,
  output logic               stack_full
);

  typedef enum logic {IDLE, SERVICE} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [1:0]         status_q, status_d;
  logic               cause_valid_q, cause_valid_d;
  logic [4:0]         cause_id_q, cause_id_d;
  logic [LVL_W-1:0]   nest_q, nest_d;
  logic [31:0]        epc_stk_q [STACK_DEPTH];
  logic [31:0]        epc_stk_d [STACK_DEPTH];
  logic [4:0]         id_stk_q  [STACK_DEPTH];
  logic [4:0]         id_stk_d  [STACK_DEPTH];

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] take_clr;
  logic [NUM_SRC-1:0] w1c;
  logic [4:0]         win_id;
  logic [4:0]         top_id;
  logic [31:0]        top_epc;
  int                 top_idx;
  logic               nest_ok;
  logic               take;

  assign eligible   = pending_q & ~mask_q;
  assign stack_full = (nest_q == LVL_W'(STACK_DEPTH));
  assign nest_level = nest_q;
  // With an empty stack, the "top" is entry 0 so MTC0/MFC0 EPC still has a target.
  assign top_idx    = (nest_q == '0) ? 0 : int'(nest_q) - 1;

  // Lowest set index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 5'(i);
    end
  end

  // Read the top-of-stack entry.
  always_comb begin
    top_id  = '0;
    top_epc = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (i == top_idx) begin
        top_id  = id_stk_q[i];
        top_epc = epc_stk_q[i];
      end
    end
  end

  // A nested take needs NEST_EN and a strictly higher priority than the one in service.
  assign nest_ok  = (state_q == IDLE) || (status_q[1] && (win_id < top_id));
  assign take     = (|eligible) && !status_q[0] && !eret && !stack_full && nest_ok;
  assign take_clr = take ? (NUM_SRC'(1) << win_id) : '0;
  assign w1c      = (cp0_we && cp0_sel == 3'd4) ? cp0_wdata[NUM_SRC-1:0] : '0;

  assign exp_take   = take;
  assign exp_vector = VEC_BASE + 32'(win_id) * VEC_STRIDE;
  assign epc        = (nest_q == '0) ? 32'h0 : top_epc;

  // MFC0 read mux; unused selects and unimplemented bits read zero.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_sel)
      3'd0: cp0_rdata = top_epc;
      3'd1: cp0_rdata[1:0] = status_q;
      3'd2: cp0_rdata[NUM_SRC-1:0] = mask_q;
      3'd3: cp0_rdata = {cause_valid_q, 26'b0, cause_id_q};
      3'd4: cp0_rdata[NUM_SRC-1:0] = pending_q;
      default: cp0_rdata = '0;
    endcase
  end

  // Next-state for registers and stack. A new edge beats any clear of the same bit,
  // and a take owns the stack this cycle so a colliding MTC0 EPC is dropped.
  always_comb begin
    pending_d     = (pending_q & ~(take_clr | w1c)) | (exp_src & ~src_q);
    mask_d        = mask_q;
    status_d      = status_q;
    cause_valid_d = cause_valid_q;
    cause_id_d    = cause_id_q;
    nest_d        = nest_q;
    epc_stk_d     = epc_stk_q;
    id_stk_d      = id_stk_q;

    if (cp0_we && cp0_sel == 3'd1) status_d = cp0_wdata[1:0];
    if (cp0_we && cp0_sel == 3'd2) mask_d = cp0_wdata[NUM_SRC-1:0];

    if (take) begin
      cause_valid_d = 1'b1;
      cause_id_d    = win_id;
      nest_d        = nest_q + LVL_W'(1);
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (i == int'(nest_q)) begin
          epc_stk_d[i] = pc_in;
          id_stk_d[i]  = win_id;
        end
      end
    end else begin
      if (cp0_we && cp0_sel == 3'd0) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (i == top_idx) epc_stk_d[i] = cp0_wdata;
        end
      end
      if (eret && nest_q != '0) nest_d = nest_q - LVL_W'(1);
    end
  end

  // Service state tracks whether anything is on the stack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = SERVICE;
      SERVICE: if (eret && nest_q == LVL_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      src_q         <= '0;
      pending_q     <= '0;
      mask_q        <= '0;
      status_q      <= '0;
      cause_valid_q <= 1'b0;
      cause_id_q    <= '0;
      nest_q        <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        epc_stk_q[i] <= '0;
        id_stk_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      src_q         <= exp_src;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      status_q      <= status_d;
      cause_valid_q <= cause_valid_d;
      cause_id_q    <= cause_id_d;
      nest_q        <= nest_d;
      epc_stk_q     <= epc_stk_d;
      id_stk_q      <= id_stk_d;
    end
  end

endmodule
